hermes_tx_monitor: RTL and testbench
====================================

// Module: hermes_tx_monitor
// PURPOSE
//  Synthesizable run-time monitor on the output side of a Hermes router. It watches every
//  output port's tx/credit_i/data_out and tracks packet framing per port (header, size, payload).
//  It flags hardware-Trojan-style misbehaviour: too many ports transmitting at once, broken
//  credit holds, and malformed packets. Sits beside the router in the NoC tile.
//  Alarms feed the tile's security/interrupt logic.
// PARAMETERS
//  NPORT       5    number of router ports (index 0..NPORT-1 = EAST,WEST,NORTH,SOUTH,LOCAL,...)
//  FLIT_W      16   flit width; the size flit is taken as an unsigned FLIT_W-bit payload count
//  MAX_ACTIVE  2    max ports allowed to assert tx in the same cycle
//  CNT_W       16   width of the saturating violation counter
// PORTS
//  clock       in   1             single clock, rising edge
//  reset       in   1             synchronous, active-high
//  enable      in   1             1 = monitoring on; 0 = trackers forced to IDLE, flags hold
//  clear       in   1             synchronous clear of sticky flags and the counter
//  tx          in   NPORT         router output valid, per port
//  credit_i    in   NPORT         downstream credit, per port; transfer = tx & credit_i
//  data_out    in   NPORT*FLIT_W  flattened output flits; port p at [p*FLIT_W +: FLIT_W]
//  alarm       out  1             sticky OR of all error flags
//  err_overlap out  1             sticky: $countones(tx) > MAX_ACTIVE was seen
//  err_hold    out  NPORT         sticky: stalled flit dropped or changed, per port
//  err_size    out  NPORT         sticky: size flit == 0, per port
//  pkt_done    out  NPORT         1-cycle pulse: last payload flit of a packet transferred
//  active_cnt  out  $clog2(NPORT+1)  registered count of ports with tx=1
//  viol_count  out  CNT_W         saturating number of violation events
// BEHAVIOUR
//  - Reset: all outputs 0; every port tracker goes to IDLE, remaining=0, hold regs cleared.
//  - Checks sample inputs at cycle t. Flags, pulses and counts are registered and visible at t+1.
//  - Port tracker FSM (states IDLE, SIZE, PAYLOAD); xfer = tx[p] & credit_i[p]:
//      IDLE    --xfer--> SIZE (header flit consumed)
//      SIZE    --xfer, flit==0--> IDLE and set err_size[p]
//      SIZE    --xfer, flit!=0--> PAYLOAD, remaining = flit
//      PAYLOAD --xfer--> remaining-1; if remaining==1, go to IDLE and pulse pkt_done[p]
//    No xfer: the state holds.
//  - Hold rule: if tx[p]=1 and credit_i[p]=0 at t, then at t+1 tx[p] must be 1 and data_out[p]
//    must equal the value at t. Otherwise set err_hold[p]. The rule applies in every FSM state.
//  - Overlap: if $countones(tx) > MAX_ACTIVE at t, set err_overlap at t+1.
//    active_cnt = $countones(tx) from t.
//  - viol_count: +1 per cycle in which any new error condition fires, regardless of how many
//    fire. It saturates at 2^CNT_W-1 and does not wrap.
//  - clear: zeroes the sticky flags and viol_count. If a violation fires in the same cycle as
//    clear, the violation wins: its flag is set and the count becomes 1. Trackers are not
//    affected by clear.
//  - enable=0: trackers and hold regs go to IDLE/cleared and no checks run.
//    Flags and the counter keep their values. Re-enabling mid-packet resynchronises on the next
//    flit, which is treated as a header.
//  - Reset mid-packet: trackers abort to IDLE; no pkt_done is pulsed.
//  - Simultaneous pkt_done on several ports is allowed, one bit per port.
// STRUCTURE
//  - Package hermes_mon_pkg holds:
//      port index localparams EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4
//      typedef enum logic [1:0] {TRK_IDLE, TRK_SIZE, TRK_PAYLOAD} trk_state_t
//  - Sub-module hermes_port_tracker (one per port, via generate) owns:
//      the FSM, the remaining counter, the hold register, and the err_hold/err_size/pkt_done
//      signals for that port.
//  - Top level owns the popcount/overlap check, the alarm OR and the saturating counter.
// TESTING
//  - LOCAL sends 0x0012,0x0002,0xAAAA,0xBBBB with credit_i=1 -> pkt_done[4] pulses one cycle
//    after 0xBBBB; all errors stay 0.
//  - tx=5'b00111 for 1 cycle, MAX_ACTIVE=2 -> err_overlap=1, alarm=1, viol_count=1,
//    active_cnt=3, all at the next cycle.
//  - EAST tx=1, credit_i=0, data 0x1234, then next cycle data 0x1235 -> err_hold[0]=1.
//    The same test with 0x1234 held is clean.
//  - NORTH header then size flit 0x0000 -> err_size[2]=1, tracker back to IDLE;
//    the next flit is accepted as a header.
//  - viol_count forced near 2^CNT_W-1 with repeated overlaps -> it stays at all-ones.
//    Then clear asserted together with an overlap -> err_overlap=1, viol_count=1.
//  - reset asserted during SOUTH payload -> all outputs 0 next cycle; no pkt_done[3].

Source files
------------

// File: rtl/hermes_mon_pkg.sv
// hermes_mon_pkg: shared port indices and tracker state type for the Hermes tx monitor
package hermes_mon_pkg;
    localparam int EAST  = 0;
    localparam int WEST  = 1;
    localparam int NORTH = 2;
    localparam int SOUTH = 3;
    localparam int LOCAL = 4;
    typedef enum logic [1:0] {TRK_IDLE, TRK_SIZE, TRK_PAYLOAD} trk_state_t;
endpackage

// File: rtl/hermes_port_tracker.sv
// hermes_port_tracker: per-port packet framing FSM, stalled-flit hold check and sticky port flags
module hermes_port_tracker
    import hermes_mon_pkg::*;
#(
    parameter int FLIT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              tx,
    input  logic              credit,
    input  logic [FLIT_W-1:0] data,
    output logic              err_hold,
    output logic              err_size,
    output logic              pkt_done,
    output logic              hold_evt,
    output logic              size_evt
);
    trk_state_t        state;
    logic [FLIT_W-1:0] remaining;
    logic [FLIT_W-1:0] held_data;
    logic              held;
    logic              xfer;
    logic              stall;
    assign xfer     = tx & credit;
    assign stall    = enable & tx & ~credit;
    assign size_evt = enable && state == TRK_SIZE && xfer && data == '0;
    // a flit stalled last cycle must still be offered, unchanged
    assign hold_evt = enable && held && (!tx || data != held_data);
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= TRK_IDLE;
            remaining <= '0;
            held      <= 1'b0;
            held_data <= '0;
            err_hold  <= 1'b0;
            err_size  <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            err_hold  <= hold_evt | (err_hold & ~clear);
            err_size  <= size_evt | (err_size & ~clear);
            pkt_done  <= enable && state == TRK_PAYLOAD && xfer && remaining == FLIT_W'(1);
            held      <= stall;
            held_data <= stall ? data : '0;
            if (!enable) begin
                state     <= TRK_IDLE;
                remaining <= '0;
            end else if (xfer) begin
                case (state)
                    TRK_IDLE: state <= TRK_SIZE;
                    TRK_SIZE: begin
                        state     <= (data == '0) ? TRK_IDLE : TRK_PAYLOAD;
                        remaining <= data;
                    end
                    default: begin
                        state     <= (remaining == FLIT_W'(1)) ? TRK_IDLE : TRK_PAYLOAD;
                        remaining <= remaining - FLIT_W'(1);
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/hermes_tx_monitor.sv
// hermes_tx_monitor: run-time Trojan monitor on Hermes router outputs (overlap, hold, framing)
module hermes_tx_monitor
    import hermes_mon_pkg::*;
#(
    parameter int NPORT      = 5,
    parameter int FLIT_W     = 16,
    parameter int MAX_ACTIVE = 2,
    parameter int CNT_W      = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [NPORT-1:0]           tx,
    input  logic [NPORT-1:0]           credit_i,
    input  logic [NPORT*FLIT_W-1:0]    data_out,
    output logic                       alarm,
    output logic                       err_overlap,
    output logic [NPORT-1:0]           err_hold,
    output logic [NPORT-1:0]           err_size,
    output logic [NPORT-1:0]           pkt_done,
    output logic [$clog2(NPORT+1)-1:0] active_cnt,
    output logic [CNT_W-1:0]           viol_count
);
    localparam int AW = $clog2(NPORT + 1);
    logic [AW-1:0]    pop;
    logic [NPORT-1:0] hold_evt;
    logic [NPORT-1:0] size_evt;
    logic             overlap_evt;
    logic             any_evt;
    always_comb begin
        pop = '0;
        for (int i = 0; i < NPORT; i++) pop = pop + AW'(tx[i]);
    end
    assign overlap_evt = enable && (int'(pop) > MAX_ACTIVE);
    assign any_evt     = overlap_evt | (|hold_evt) | (|size_evt);
    assign alarm       = err_overlap | (|err_hold) | (|err_size);
    for (genvar p = 0; p < NPORT; p++) begin : g_trk
        hermes_port_tracker #(.FLIT_W(FLIT_W)) u_trk (
            .clock    (clock),
            .reset    (reset),
            .enable   (enable),
            .clear    (clear),
            .tx       (tx[p]),
            .credit   (credit_i[p]),
            .data     (data_out[p*FLIT_W +: FLIT_W]),
            .err_hold (err_hold[p]),
            .err_size (err_size[p]),
            .pkt_done (pkt_done[p]),
            .hold_evt (hold_evt[p]),
            .size_evt (size_evt[p])
        );
    end
    // a violation coinciding with clear restarts the count at 1
    always_ff @(posedge clock) begin
        if (reset) begin
            active_cnt  <= '0;
            err_overlap <= 1'b0;
            viol_count  <= '0;
        end else begin
            active_cnt  <= pop;
            err_overlap <= overlap_evt | (err_overlap & ~clear);
            viol_count  <= clear ? CNT_W'(any_evt)
                         : (any_evt && ~&viol_count) ? viol_count + CNT_W'(1) : viol_count;
        end
    end
endmodule

// File: tb/tb_hermes_tx_monitor.sv
// tb_hermes_tx_monitor: directed vectors with hand-computed expectations for hermes_tx_monitor
module tb_hermes_tx_monitor;
    import hermes_mon_pkg::*;
    localparam int NPORT = 5;
    localparam int FW    = 16;
    localparam int CW    = 4;
    logic              clock = 1'b0;
    logic              reset, enable, clear;
    logic [NPORT-1:0]  tx, credit_i;
    logic [NPORT*FW-1:0] data_out;
    logic              alarm, err_overlap;
    logic [NPORT-1:0]  err_hold, err_size, pkt_done;
    logic [2:0]        active_cnt;
    logic [CW-1:0]     viol_count;
    int                n_vec = 0;
    int                n_bad = 0;

    hermes_tx_monitor #(.NPORT(NPORT), .FLIT_W(FW), .MAX_ACTIVE(2), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .tx          (tx),
        .credit_i    (credit_i),
        .data_out    (data_out),
        .alarm       (alarm),
        .err_overlap (err_overlap),
        .err_hold    (err_hold),
        .err_size    (err_size),
        .pkt_done    (pkt_done),
        .active_cnt  (active_cnt),
        .viol_count  (viol_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic setd(input int p, input logic [FW-1:0] v);
        data_out[p*FW +: FW] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alarm"}, 32'(alarm), 0);
        chk({tag, "_overlap"}, 32'(err_overlap), 0);
        chk({tag, "_hold"}, 32'(err_hold), 0);
        chk({tag, "_size"}, 32'(err_size), 0);
        chk({tag, "_done"}, 32'(pkt_done), 0);
        chk({tag, "_active"}, 32'(active_cnt), 0);
        chk({tag, "_viol"}, 32'(viol_count), 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0;
        tx = '0; credit_i = '0; data_out = '0;
        cyc(); cyc();
        chk_all_zero("reset");
        reset = 1'b0; enable = 1'b1;

        // LOCAL four-flit packet
        tx = 5'b10000; credit_i = 5'b10000; setd(LOCAL, 16'h0012); cyc();
        chk("local_active", 32'(active_cnt), 1);
        setd(LOCAL, 16'h0002); cyc();
        setd(LOCAL, 16'hAAAA); cyc();
        chk("local_done_early", 32'(pkt_done), 0);
        setd(LOCAL, 16'hBBBB); cyc();
        chk("local_done", 32'(pkt_done), 32'h10);
        tx = '0; credit_i = '0; cyc();
        chk("local_done_pulse", 32'(pkt_done), 0);
        chk("local_alarm", 32'(alarm), 0);
        chk("local_viol", 32'(viol_count), 0);

        // three ports at once
        tx = 5'b00111; credit_i = 5'b00111;
        setd(EAST, 16'h1); setd(WEST, 16'h1); setd(NORTH, 16'h1); cyc();
        chk("ovl_flag", 32'(err_overlap), 1);
        chk("ovl_alarm", 32'(alarm), 1);
        chk("ovl_viol", 32'(viol_count), 1);
        chk("ovl_active", 32'(active_cnt), 3);
        tx = '0; credit_i = '0; enable = 1'b0; clear = 1'b1; cyc();
        chk("clr_overlap", 32'(err_overlap), 0);
        chk("clr_viol", 32'(viol_count), 0);
        enable = 1'b1; clear = 1'b0;

        // stalled flit held correctly
        tx = 5'b00001; credit_i = '0; setd(EAST, 16'h1234); cyc(); cyc();
        chk("hold_ok1", 32'(err_hold), 0);
        credit_i = 5'b00001; cyc();
        chk("hold_ok2", 32'(err_hold), 0);
        chk("hold_ok_viol", 32'(viol_count), 0);
        tx = '0; credit_i = '0; enable = 1'b0; cyc();
        enable = 1'b1;

        // stalled flit changed
        tx = 5'b00001; credit_i = '0; setd(EAST, 16'h1234); cyc();
        setd(EAST, 16'h1235); credit_i = 5'b00001; cyc();
        chk("hold_bad", 32'(err_hold), 1);
        chk("hold_bad_viol", 32'(viol_count), 1);
        chk("hold_bad_alarm", 32'(alarm), 1);
        tx = '0; credit_i = '0; enable = 1'b0; clear = 1'b1; cyc();
        chk("hold_clr", 32'(err_hold), 0);
        enable = 1'b1; clear = 1'b0;

        // zero size flit, then resync
        tx = 5'b00100; credit_i = 5'b00100; setd(NORTH, 16'h0001); cyc();
        setd(NORTH, 16'h0000); cyc();
        chk("size_flag", 32'(err_size), 32'h4);
        chk("size_viol", 32'(viol_count), 1);
        setd(NORTH, 16'h0003); cyc();
        setd(NORTH, 16'h0001); cyc();
        setd(NORTH, 16'h7777); cyc();
        chk("size_resync_done", 32'(pkt_done), 32'h4);
        chk("size_sticky", 32'(err_size), 32'h4);
        chk("size_viol_keep", 32'(viol_count), 1);
        tx = '0; credit_i = '0; cyc();
        clear = 1'b1; cyc();
        clear = 1'b0;
        chk("size_clr_viol", 32'(viol_count), 0);

        // saturation with stalled but stable overlapping ports
        tx = 5'b00111; credit_i = '0;
        repeat (14) cyc();
        chk("sat_14", 32'(viol_count), 14);
        cyc();
        chk("sat_15", 32'(viol_count), 15);
        repeat (3) cyc();
        chk("sat_hold", 32'(viol_count), 15);
        chk("sat_no_hold_err", 32'(err_hold), 0);
        clear = 1'b1; credit_i = 5'b00111; cyc();
        chk("clr_ovl_flag", 32'(err_overlap), 1);
        chk("clr_ovl_viol", 32'(viol_count), 1);
        tx = '0; credit_i = '0; enable = 1'b0; cyc();
        chk("clr2_viol", 32'(viol_count), 0);
        enable = 1'b1; clear = 1'b0;

        // reset during SOUTH payload
        tx = 5'b01000; credit_i = 5'b01000; setd(SOUTH, 16'h0009); cyc();
        setd(SOUTH, 16'h0003); cyc();
        tx = 5'b01011; credit_i = 5'b01011; setd(SOUTH, 16'hAAAA); cyc();
        chk("pre_rst_overlap", 32'(err_overlap), 1);
        tx = 5'b01000; credit_i = 5'b01000; setd(SOUTH, 16'hBBBB); reset = 1'b1; cyc();
        chk_all_zero("midrst");
        reset = 1'b0; setd(SOUTH, 16'hCCCC); cyc();
        chk("post_rst_hdr", 32'(pkt_done), 0);
        setd(SOUTH, 16'h0001); cyc();
        chk("post_rst_size", 32'(pkt_done), 0);
        setd(SOUTH, 16'hDDDD); cyc();
        chk("post_rst_done", 32'(pkt_done), 32'h8);
        tx = '0; credit_i = '0; cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
